// File: rtl/rom_image_fetch.sv
// rtl/rom_image_fetch.sv - places a ROM-held RGB565 image on the TFT visible area over a fill colour.
// Optional colour-bar test pattern: define ROM_IMAGE_FETCH_TEST_PATTERN_EN to add the test_mode input.
module rom_image_fetch #(
    parameter int          IMG_W    = 128,
    parameter int          IMG_H    = 128,
    parameter int          IMG_X    = 100,
    parameter int          IMG_Y    = 80,
    parameter int          ROM_LAT  = 2,
    parameter int          ADDR_W   = 14,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic              clk_ctrl,
    input  logic              reset,
    input  logic              disp_data_req,
    input  logic [11:0]       visible_hcount,
    input  logic [11:0]       visible_vcount,
    input  logic              frame_begin,
`ifdef ROM_IMAGE_FETCH_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [15:0]       rom_data,
    output logic [15:0]       disp_data,
    output logic              frame_done
);

    localparam int                LAT       = ROM_LAT + 1;
    localparam logic [31:0]       H_LO      = 32'(IMG_X - LAT);
    localparam logic [31:0]       H_HI      = 32'(IMG_X - LAT + IMG_W);
    localparam logic [31:0]       V_LO      = 32'(IMG_Y);
    localparam logic [31:0]       V_HI      = 32'(IMG_Y + IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {
        S_WAIT_FRAME,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic [ADDR_W-1:0] w_addr_cnt_nxt;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_rom_rd;
    logic              r_frame_done;
    logic              w_last;
    logic [LAT-1:0]    r_hit_sr;
    logic              w_hit;
    logic              w_hit_d;
    logic              w_in_window;
    logic              w_rd_en;
    logic [31:0]       w_h32;
    logic [31:0]       w_v32;

    assign w_h32 = {20'd0, visible_hcount};
    assign w_v32 = {20'd0, visible_vcount};

    // Window is shifted LAT columns left so the fetched pixel arrives on its own column.
    assign w_in_window = disp_data_req
                       && (w_v32 >= V_LO) && (w_v32 < V_HI)
                       && (w_h32 >= H_LO) && (w_h32 < H_HI);

    // A frame start pre-empts any fetch in the same cycle.
    assign w_hit   = w_in_window && (r_state == S_ACTIVE) && !frame_begin;
    assign w_hit_d = r_hit_sr[LAT-1];

`ifdef ROM_IMAGE_FETCH_TEST_PATTERN_EN
    localparam logic [31:0] BAR_W = 32'(IMG_W / 8);

    logic [31:0]       w_col_off;
    logic [2:0]        w_bar_idx;
    logic [2:0]        r_bar_sr [LAT];
    logic [LAT-1:0]    r_tm_sr;
    logic [15:0]       w_bar_color;

    assign w_col_off = w_h32 - H_LO;
    assign w_bar_idx = 3'(w_col_off / BAR_W);
    assign w_rd_en   = w_hit && !test_mode;

    always_ff @(posedge clk_ctrl or posedge reset) begin
        if (reset) begin
            r_tm_sr <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_bar_sr[i] <= 3'd0;
            end
        end else begin
            r_tm_sr     <= {r_tm_sr[LAT-2:0], test_mode};
            r_bar_sr[0] <= w_bar_idx;
            for (int i = 1; i < LAT; i++) begin
                r_bar_sr[i] <= r_bar_sr[i-1];
            end
        end
    end

    always_comb begin
        w_bar_color = 16'h0000;
        case (r_bar_sr[LAT-1])
            3'd0:    w_bar_color = 16'hFFFF;
            3'd1:    w_bar_color = 16'hFFE0;
            3'd2:    w_bar_color = 16'h07FF;
            3'd3:    w_bar_color = 16'h07E0;
            3'd4:    w_bar_color = 16'hF81F;
            3'd5:    w_bar_color = 16'hF800;
            3'd6:    w_bar_color = 16'h001F;
            default: w_bar_color = 16'h0000;
        endcase
    end

    always_comb begin
        disp_data = BG_COLOR;
        if (w_hit_d) begin
            disp_data = r_tm_sr[LAT-1] ? w_bar_color : rom_data;
        end
    end
`else
    assign w_rd_en = w_hit;

    always_comb begin
        disp_data = BG_COLOR;
        if (w_hit_d) begin
            disp_data = rom_data;
        end
    end
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_cnt_nxt = r_addr_cnt;
        w_last         = 1'b0;
        if (frame_begin) begin
            w_state_nxt    = S_ACTIVE;
            w_addr_cnt_nxt = '0;
        end else if (w_hit) begin
            w_addr_cnt_nxt = r_addr_cnt + 1'b1;
            if (r_addr_cnt == LAST_ADDR) begin
                w_state_nxt = S_DONE;
                w_last      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_ctrl or posedge reset) begin
        if (reset) begin
            r_state      <= S_WAIT_FRAME;
            r_addr_cnt   <= '0;
            r_rom_addr   <= '0;
            r_rom_rd     <= 1'b0;
            r_frame_done <= 1'b0;
            r_hit_sr     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr_cnt   <= w_addr_cnt_nxt;
            r_rom_rd     <= w_rd_en;
            r_frame_done <= w_last;
            r_hit_sr     <= {r_hit_sr[LAT-2:0], w_hit};
            if (w_hit) begin
                r_rom_addr <= r_addr_cnt;
            end
        end
    end

    assign rom_addr   = r_rom_addr;
    assign rom_rd     = r_rom_rd;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_rom_image_fetch.sv
// tb/tb_rom_image_fetch.sv - directed self-checking bench for rom_image_fetch with a 2-cycle ROM model.
module tb_rom_image_fetch;

    localparam int H_VIS = 232;
    localparam int H_TOT = 240;

    logic        clk;
    logic        rst;
    logic        req;
    logic [11:0] hc;
    logic [11:0] vc;
    logic        fb;
    logic        tm;
    logic [13:0] rom_addr;
    logic        rom_rd;
    logic [15:0] rom_data;
    logic [15:0] rom_p1;
    logic [15:0] disp;
    logic        fd;

    int total;
    int bad;
    int fd_seen;
    int f_cnt;
    int d_cnt;
    bit f_act;
    bit d_act;
    bit p_rd;
    int p_addr;
    bit p_last;
    bit spot_en;
    bit tm_spot_en;

    rom_image_fetch dut (
        .clk_ctrl       (clk),
        .reset          (rst),
        .disp_data_req  (req),
        .visible_hcount (hc),
        .visible_vcount (vc),
        .frame_begin    (fb),
`ifdef ROM_IMAGE_FETCH_TEST_PATTERN_EN
        .test_mode      (tm),
`endif
        .rom_addr       (rom_addr),
        .rom_rd         (rom_rd),
        .rom_data       (rom_data),
        .disp_data      (disp),
        .frame_done     (fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_val(input logic [13:0] a);
        return {2'b10, a};
    endfunction

    function automatic logic [15:0] bar_color(input int idx);
        case (idx)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // ROM answers whatever address is presented, read enable or not.
    always_ff @(posedge clk) begin
        rom_p1   <= rom_val(rom_addr);
        rom_data <= rom_p1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r_in, input bit req_in, input int h, input int v, input bit fb_in);
        bit          in_disp;
        bit          hit;
        logic [15:0] ed;
        @(posedge clk);
        #1;
        rst = r_in;
        req = req_in;
        hc  = 12'(h);
        vc  = 12'(v);
        fb  = fb_in;
        @(negedge clk);
        in_disp = req_in && v >= 80 && v < 208 && h >= 100 && h < 228;
        hit     = 1'b0;
        if (r_in) begin
            f_act  = 1'b0;
            d_act  = 1'b0;
            p_rd   = 1'b0;
            p_last = 1'b0;
        end
        ed = 16'h0000;
        if (d_act && in_disp) ed = tm ? bar_color((h - 100) / 16) : rom_val(14'(d_cnt));
        chk("disp", {16'd0, disp}, {16'd0, ed});
        chk("rd", {31'd0, rom_rd}, {31'd0, p_rd});
        if (p_rd) chk("addr", {18'd0, rom_addr}, 32'(p_addr));
        chk("fd", {31'd0, fd}, {31'd0, p_last});
        if (fd) fd_seen++;
        if (!r_in) begin
            if (fb_in) begin
                f_act = 1'b1;
                f_cnt = 0;
                d_act = 1'b1;
                d_cnt = 0;
            end else begin
                hit = f_act && req_in && v >= 80 && v < 208 && h >= 97 && h < 225;
            end
        end
        p_rd   = hit && !tm;
        p_addr = f_cnt;
        p_last = hit && (f_cnt == 16383);
        if (hit) begin
            f_cnt++;
            if (f_cnt == 16384) f_act = 1'b0;
        end
        if (!r_in && !fb_in && d_act && in_disp) begin
            d_cnt++;
            if (d_cnt == 16384) d_act = 1'b0;
        end
    endtask

    task automatic spot(input int v, input int h);
        if (spot_en) begin
            if (v == 80 && h == 97)  chk("first_rd_early", {31'd0, rom_rd}, 32'd0);
            if (v == 80 && h == 98)  chk("first_rd", {31'd0, rom_rd}, 32'd1);
            if (v == 80 && h == 98)  chk("first_addr", {18'd0, rom_addr}, 32'd0);
            if (v == 80 && h == 99)  chk("px_80_99", {16'd0, disp}, 32'h0000);
            if (v == 80 && h == 100) chk("px_80_100", {16'd0, disp}, 32'h8000);
            if (v == 80 && h == 227) chk("px_80_227", {16'd0, disp}, 32'h807F);
            if (v == 80 && h == 228) chk("px_80_228", {16'd0, disp}, 32'h0000);
            if (v == 81 && h == 100) chk("px_81_100", {16'd0, disp}, 32'h8080);
            if (v == 207 && h == 225) chk("fd_pulse", {31'd0, fd}, 32'd1);
            if (v == 208 && h == 150) chk("px_208_150", {16'd0, disp}, 32'h0000);
        end
        if (tm_spot_en) begin
            if (v == 80 && h == 100) chk("bar_100", {16'd0, disp}, 32'hFFFF);
            if (v == 80 && h == 116) chk("bar_116", {16'd0, disp}, 32'hFFE0);
            if (v == 80 && h == 211) chk("bar_211", {16'd0, disp}, 32'h001F);
            if (v == 80 && h == 212) chk("bar_212", {16'd0, disp}, 32'h0000);
            if (v == 80 && h == 98)  chk("bar_rd", {31'd0, rom_rd}, 32'd0);
        end
    endtask

    task automatic drive_line(input int v);
        for (int h = 0; h < H_TOT; h++) begin
            step(1'b0, h < H_VIS, (h < H_VIS) ? h : 0, v, 1'b0);
            spot(v, h);
        end
    endtask

    task automatic drive_lines(input int v0, input int v1);
        for (int v = v0; v <= v1; v++) drive_line(v);
    endtask

    task automatic pulse_fb();
        step(1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    initial begin
        total = 0; bad = 0; fd_seen = 0;
        f_cnt = 0; d_cnt = 0; f_act = 0; d_act = 0;
        p_rd = 0; p_addr = 0; p_last = 0;
        spot_en = 0; tm_spot_en = 0;
        rst = 1'b1; req = 1'b0; hc = '0; vc = '0; fb = 1'b0; tm = 1'b0;

        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0, 0, 1'b0);
        drive_lines(78, 82);

        spot_en = 1;
        fd_seen = 0;
        pulse_fb();
        drive_lines(78, 209);
        chk("fd_count_full", 32'(fd_seen), 32'd1);

        fd_seen = 0;
        spot_en = 0;
        pulse_fb();
        drive_lines(79, 149);
        pulse_fb();
        drive_lines(150, 160);
        chk("fd_count_trunc", 32'(fd_seen), 32'd0);
        spot_en = 1;
        pulse_fb();
        drive_lines(79, 81);

        spot_en = 0;
        pulse_fb();
        drive_lines(78, 119);
        for (int h = 0; h < H_TOT; h++) begin
            step((h >= 150 && h < 153), h < H_VIS, (h < H_VIS) ? h : 0, 120, 1'b0);
        end
        drive_lines(121, 125);
        spot_en = 1;
        pulse_fb();
        drive_lines(79, 81);
        spot_en = 0;

`ifdef ROM_IMAGE_FETCH_TEST_PATTERN_EN
        tm = 1'b1;
        tm_spot_en = 1;
        pulse_fb();
        drive_lines(79, 81);
        tm_spot_en = 0;
        tm = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
